// File: rtl/threshold_ctrl.sv
// Threshold bound controller: double-buffered bound registers committed
// at frame start, plus a per-frame saturating mask-pixel counter.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   cfg_valid_in/ready_out  shadow register write handshake
//   cfg_addr_in/data_in     0=lower_a 1=upper_a 2=lower_b 3=upper_b
//   cfg_commit_in           request shadow->active copy at next frame
//   frame_start_in          frame boundary pulse (blanking)
//   pixel_valid_in, mask_in pixel strobe and its mask, one cycle later
//   *_bound_out(b)          active bounds, channels a and b
//   commit_pending_out      commit armed, waiting for frame start
//   frame_active_out        a frame start has been seen since reset
//   mask_count_out/valid    count of last completed frame + pulse
module threshold_ctrl #(
    parameter int         COUNT_W   = 20,
    parameter logic [7:0] DEF_LOWER = 8'd0,
    parameter logic [7:0] DEF_UPPER = 8'd255
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               cfg_valid_in,
    output logic               cfg_ready_out,
    input  logic [1:0]         cfg_addr_in,
    input  logic [7:0]         cfg_data_in,
    input  logic               cfg_commit_in,
    input  logic               frame_start_in,
    input  logic               pixel_valid_in,
    input  logic               mask_in,
    output logic [7:0]         lower_bound_out,
    output logic [7:0]         upper_bound_out,
    output logic [7:0]         lower_bound_outb,
    output logic [7:0]         upper_bound_outb,
    output logic               commit_pending_out,
    output logic               frame_active_out,
    output logic [COUNT_W-1:0] mask_count_out,
    output logic               mask_count_valid_out
);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    state_t r_state;
    logic   r_cfg_ready;
    logic   r_pending;

    logic [7:0] r_shd_lower_a;
    logic [7:0] r_shd_upper_a;
    logic [7:0] r_shd_lower_b;
    logic [7:0] r_shd_upper_b;

    logic [7:0] r_act_lower_a;
    logic [7:0] r_act_upper_a;
    logic [7:0] r_act_lower_b;
    logic [7:0] r_act_upper_b;

    logic               r_valid_d;
    logic               r_frame_active;
    logic [COUNT_W-1:0] r_counter;
    logic [COUNT_W-1:0] r_mask_count;
    logic               r_mask_count_valid;

    logic               w_wr_en;
    logic               w_cnt_bit;
    logic [COUNT_W-1:0] w_cnt_next;

    // Ready is a registered copy of "in IDLE", so gating on it freezes
    // the shadows for exactly the PENDING window.
    assign w_wr_en = cfg_valid_in && r_cfg_ready;

    // Mask bits before the first frame start belong to no frame.
    assign w_cnt_bit = r_valid_d && mask_in && r_frame_active;

    always_comb begin
        w_cnt_next = r_counter;
        if (w_cnt_bit && (r_counter != CNT_MAX)) begin
            w_cnt_next = r_counter + CNT_ONE;
        end
    end

    // Commit FSM and active bound registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= ST_IDLE;
            r_cfg_ready   <= 1'b1;
            r_pending     <= 1'b0;
            r_act_lower_a <= DEF_LOWER;
            r_act_upper_a <= DEF_UPPER;
            r_act_lower_b <= DEF_LOWER;
            r_act_upper_b <= DEF_UPPER;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // A coincident frame start does not apply this
                    // commit; it waits for the following one.
                    if (cfg_commit_in) begin
                        r_state     <= ST_PENDING;
                        r_cfg_ready <= 1'b0;
                        r_pending   <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (frame_start_in) begin
                        r_state       <= ST_IDLE;
                        r_cfg_ready   <= 1'b1;
                        r_pending     <= 1'b0;
                        r_act_lower_a <= r_shd_lower_a;
                        r_act_upper_a <= r_shd_upper_a;
                        r_act_lower_b <= r_shd_lower_b;
                        r_act_upper_b <= r_shd_upper_b;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b1;
                    r_pending   <= 1'b0;
                end
            endcase
        end
    end

    // Shadow registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_shd_lower_a <= DEF_LOWER;
            r_shd_upper_a <= DEF_UPPER;
            r_shd_lower_b <= DEF_LOWER;
            r_shd_upper_b <= DEF_UPPER;
        end else if (w_wr_en) begin
            unique case (cfg_addr_in)
                2'd0: r_shd_lower_a <= cfg_data_in;
                2'd1: r_shd_upper_a <= cfg_data_in;
                2'd2: r_shd_lower_b <= cfg_data_in;
                2'd3: r_shd_upper_b <= cfg_data_in;
                default: ;
            endcase
        end
    end

    // Mask counter and per-frame publish
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_d          <= 1'b0;
            r_frame_active     <= 1'b0;
            r_counter          <= '0;
            r_mask_count       <= '0;
            r_mask_count_valid <= 1'b0;
        end else begin
            // A pixel strobed on the frame start cycle is dropped.
            r_valid_d          <= pixel_valid_in && !frame_start_in;
            r_mask_count_valid <= 1'b0;
            if (frame_start_in) begin
                r_counter      <= '0;
                r_frame_active <= 1'b1;
                // The last mask of a frame may land on this cycle.
                if (r_frame_active) begin
                    r_mask_count       <= w_cnt_next;
                    r_mask_count_valid <= 1'b1;
                end
            end else begin
                r_counter <= w_cnt_next;
            end
        end
    end

    assign cfg_ready_out        = r_cfg_ready;
    assign commit_pending_out   = r_pending;
    assign lower_bound_out      = r_act_lower_a;
    assign upper_bound_out      = r_act_upper_a;
    assign lower_bound_outb     = r_act_lower_b;
    assign upper_bound_outb     = r_act_upper_b;
    assign frame_active_out     = r_frame_active;
    assign mask_count_out       = r_mask_count;
    assign mask_count_valid_out = r_mask_count_valid;

endmodule

// File: tb/tb_threshold_ctrl.sv
// Directed bench for threshold_ctrl: bound commit timing, shadow freeze,
// mask counting and saturation (second instance with COUNT_W=4), reset.
module tb_threshold_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_commit;
    logic       fs;
    logic       pix_valid;
    logic       mask;

    logic [7:0]  lo_a, up_a, lo_b, up_b;
    logic        pending, factive, cnt_valid;
    logic [19:0] cnt;

    logic        s_ready, s_pending, s_factive, s_cnt_valid;
    logic [7:0]  s_lo_a, s_up_a, s_lo_b, s_up_b;
    logic [3:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    threshold_ctrl dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .cfg_valid_in         (cfg_valid),
        .cfg_ready_out        (cfg_ready),
        .cfg_addr_in          (cfg_addr),
        .cfg_data_in          (cfg_data),
        .cfg_commit_in        (cfg_commit),
        .frame_start_in       (fs),
        .pixel_valid_in       (pix_valid),
        .mask_in              (mask),
        .lower_bound_out      (lo_a),
        .upper_bound_out      (up_a),
        .lower_bound_outb     (lo_b),
        .upper_bound_outb     (up_b),
        .commit_pending_out   (pending),
        .frame_active_out     (factive),
        .mask_count_out       (cnt),
        .mask_count_valid_out (cnt_valid)
    );

    threshold_ctrl #(.COUNT_W(4)) dut4 (
        .clk_in               (clk),
        .rst_in               (rst),
        .cfg_valid_in         (cfg_valid),
        .cfg_ready_out        (s_ready),
        .cfg_addr_in          (cfg_addr),
        .cfg_data_in          (cfg_data),
        .cfg_commit_in        (cfg_commit),
        .frame_start_in       (fs),
        .pixel_valid_in       (pix_valid),
        .mask_in              (mask),
        .lower_bound_out      (s_lo_a),
        .upper_bound_out      (s_up_a),
        .lower_bound_outb     (s_lo_b),
        .upper_bound_outb     (s_up_b),
        .commit_pending_out   (s_pending),
        .frame_active_out     (s_factive),
        .mask_count_out       (s_cnt),
        .mask_count_valid_out (s_cnt_valid)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b exp 1", cfg_ready);
        end
        n_checks++;
        if (pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending: got %b exp 0", pending);
        end
        n_checks++;
        if ({lo_a, up_a, lo_b, up_b} !== {8'd0, 8'd255, 8'd0, 8'd255}) begin
            n_fail++;
            $display("FAIL reset_bounds: got %0d %0d %0d %0d exp 0 255 0 255",
                     lo_a, up_a, lo_b, up_b);
        end
        n_checks++;
        if ({factive, cnt_valid} !== 2'b00 || cnt !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_count: got act=%b v=%b c=%0d exp 0 0 0",
                     factive, cnt_valid, cnt);
        end
    endtask

    task automatic test_commit_basic();
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd20;
        step();
        cfg_addr = 2'd1; cfg_data = 8'd200;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if (lo_a !== 8'd0 || up_a !== 8'd255) begin
            n_fail++;
            $display("FAIL write_no_effect: got %0d %0d exp 0 255", lo_a, up_a);
        end
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_pending: got p=%b r=%b exp 1 0",
                     pending, cfg_ready);
        end
        step();
        fs = 1'b1;
        n_checks++;
        if (lo_a !== 8'd0 || up_a !== 8'd255) begin
            n_fail++;
            $display("FAIL before_fs: got %0d %0d exp 0 255", lo_a, up_a);
        end
        step();
        fs = 1'b0;
        n_checks++;
        if (lo_a !== 8'd20 || up_a !== 8'd200) begin
            n_fail++;
            $display("FAIL after_fs: got %0d %0d exp 20 200", lo_a, up_a);
        end
        n_checks++;
        if (pending !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL back_idle: got p=%b r=%b exp 0 1", pending, cfg_ready);
        end
        n_checks++;
        if (factive !== 1'b1 || cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_frame: got act=%b v=%b exp 1 0",
                     factive, cnt_valid);
        end
    endtask

    task automatic test_pending_write();
        cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd50;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd99;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_ready: got %b exp 0", cfg_ready);
        end
        step();
        cfg_addr = 2'd0; cfg_data = 8'd77; cfg_commit = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_hold: got %b exp 1", pending);
        end
        fs = 1'b1;
        step();
        fs = 1'b0;
        n_checks++;
        if ({lo_a, up_a, lo_b, up_b} !== {8'd20, 8'd200, 8'd50, 8'd255}) begin
            n_fail++;
            $display("FAIL pend_frozen: got %0d %0d %0d %0d exp 20 200 50 255",
                     lo_a, up_a, lo_b, up_b);
        end
        n_checks++;
        if (cnt_valid !== 1'b1 || cnt !== 20'd0) begin
            n_fail++;
            $display("FAIL empty_frame: got v=%b c=%0d exp 1 0", cnt_valid, cnt);
        end
    endtask

    task automatic test_write_and_commit();
        cfg_valid = 1'b1; cfg_addr = 2'd3; cfg_data = 8'd128;
        cfg_commit = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || up_b !== 8'd255) begin
            n_fail++;
            $display("FAIL wc_pending: got p=%b ub=%0d exp 1 255", pending, up_b);
        end
        fs = 1'b1;
        step();
        fs = 1'b0;
        n_checks++;
        if (up_b !== 8'd128) begin
            n_fail++;
            $display("FAIL wc_applied: got %0d exp 128", up_b);
        end
    endtask

    task automatic test_mask_count();
        logic [9:0] pat;
        pat = 10'b1110101101;
        fs = 1'b1;
        step();
        fs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1;
            mask = (i > 0) ? pat[i-1] : 1'b0;
            step();
        end
        pix_valid = 1'b0;
        mask = pat[9];
        fs = 1'b1;
        step();
        fs = 1'b0;
        mask = 1'b0;
        n_checks++;
        if (cnt !== 20'd7 || cnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL count7: got c=%0d v=%b exp 7 1", cnt, cnt_valid);
        end
        step();
        n_checks++;
        if (cnt !== 20'd7 || cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL count7_pulse: got c=%0d v=%b exp 7 0", cnt, cnt_valid);
        end
    endtask

    task automatic test_commit_with_fs();
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd33;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b1; fs = 1'b1;
        step();
        cfg_commit = 1'b0; fs = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || lo_a !== 8'd20) begin
            n_fail++;
            $display("FAIL cfs_same: got p=%b la=%0d exp 1 20", pending, lo_a);
        end
        step();
        step();
        step();
        n_checks++;
        if (lo_a !== 8'd20) begin
            n_fail++;
            $display("FAIL cfs_wait: got %0d exp 20", lo_a);
        end
        fs = 1'b1;
        step();
        fs = 1'b0;
        n_checks++;
        if (lo_a !== 8'd33 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL cfs_next: got la=%0d p=%b exp 33 0", lo_a, pending);
        end
    endtask

    task automatic test_saturation();
        fs = 1'b1;
        step();
        fs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            mask = (i > 0);
            step();
        end
        pix_valid = 1'b0;
        mask = 1'b1;
        fs = 1'b1;
        step();
        fs = 1'b0;
        mask = 1'b0;
        n_checks++;
        if (s_cnt !== 4'd15 || s_cnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sat4: got c=%0d v=%b exp 15 1", s_cnt, s_cnt_valid);
        end
        n_checks++;
        if (cnt !== 20'd20) begin
            n_fail++;
            $display("FAIL count20: got %0d exp 20", cnt);
        end
    endtask

    task automatic test_reset_pending();
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd222;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_valid = (i < 3);
            mask = (i > 0);
            step();
        end
        pix_valid = 1'b0;
        mask = 1'b0;
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rp_armed: got %b exp 1", pending);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (pending !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rp_fsm: got p=%b r=%b exp 0 1", pending, cfg_ready);
        end
        n_checks++;
        if ({lo_a, up_a, lo_b, up_b} !== {8'd0, 8'd255, 8'd0, 8'd255}) begin
            n_fail++;
            $display("FAIL rp_bounds: got %0d %0d %0d %0d exp 0 255 0 255",
                     lo_a, up_a, lo_b, up_b);
        end
        n_checks++;
        if (factive !== 1'b0 || cnt !== 20'd0 || cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rp_count: got act=%b c=%0d v=%b exp 0 0 0",
                     factive, cnt, cnt_valid);
        end
        fs = 1'b1;
        step();
        fs = 1'b0;
        n_checks++;
        if (cnt_valid !== 1'b0 || factive !== 1'b1) begin
            n_fail++;
            $display("FAIL rp_nopub: got v=%b act=%b exp 0 1", cnt_valid, factive);
        end
        n_checks++;
        if (up_a !== 8'd255 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rp_discard: got ua=%0d p=%b exp 255 0", up_a, pending);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_addr   = 2'd0;
        cfg_data   = 8'd0;
        cfg_commit = 1'b0;
        fs         = 1'b0;
        pix_valid  = 1'b0;
        mask       = 1'b0;
        step();
        test_reset();
        test_commit_basic();
        test_pending_write();
        test_write_and_commit();
        test_mask_count();
        test_commit_with_fs();
        test_saturation();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/threshold_ctrl.md
THRESHOLD_CTRL -- requirements
Module: threshold_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 20, width of the per-frame mask-pixel counter.
REQ-002 SHALL have parameter DEF_LOWER, default 8'd0, reset value of both lower bounds.
REQ-003 SHALL have parameter DEF_UPPER, default 8'd255, reset value of both upper bounds.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_in  input  1  clock; all logic on posedge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 cfg_valid_in  input  1  config write request.
REQ-007 cfg_ready_out  output  1  shadow registers accept a write.
REQ-008 cfg_addr_in  input  2  0=lower_a, 1=upper_a, 2=lower_b, 3=upper_b.
REQ-009 cfg_data_in  input  8  bound value.
REQ-010 cfg_commit_in  input  1  pulse; request shadow-to-active copy at next frame start.
REQ-011 frame_start_in  input  1  single-cycle pulse in blanking, before a frame's first pixel.
REQ-012 pixel_valid_in  input  1  pixel presented to the threshold datapath this cycle.
REQ-013 mask_in  input  1  threshold mask output; 1 cycle after its pixel_valid_in.
REQ-014 lower_bound_out, upper_bound_out  output  8 each  active bounds, channel a.
REQ-015 lower_bound_outb, upper_bound_outb  output  8 each  active bounds, channel b.
REQ-016 commit_pending_out  output  1  high while in PENDING.
REQ-017 frame_active_out  output  1  at least one frame_start seen since reset.
REQ-018 mask_count_out  output  COUNT_W  mask-pixel count of the last completed frame.
REQ-019 mask_count_valid_out  output  1  one-cycle pulse when mask_count_out updates.

Function
REQ-020 Config handshake: a write SHALL occur on the cycle cfg_valid_in && cfg_ready_out; shadow[cfg_addr_in] <= cfg_data_in; active outputs are unaffected.
REQ-021 cfg_ready_out SHALL be 1 in IDLE and 0 in PENDING; shadows are frozen while PENDING.
REQ-022 Commit FSM states: IDLE, PENDING; IDLE->PENDING on cfg_commit_in; PENDING->IDLE on frame_start_in.
REQ-023 On the PENDING->IDLE transition, all four active bounds SHALL load from the shadows; new values are visible on outputs the cycle after frame_start_in.
REQ-024 A write and cfg_commit_in in the same IDLE cycle SHALL both take effect; the written value is included in the commit.
REQ-025 cfg_commit_in together with frame_start_in in IDLE SHALL enter PENDING and apply at the NEXT frame_start_in, not the current one.
REQ-026 cfg_commit_in while PENDING SHALL be ignored.
REQ-027 Mask qualification: valid_d <= pixel_valid_in; a mask bit counts iff valid_d && mask_in.
REQ-028 Counter SHALL increment by 1 per counted bit and saturate at 2^COUNT_W-1.
REQ-029 On frame_start_in with frame_active_out=1: mask_count_out <= counter + (counted bit this cycle, saturating); mask_count_valid_out=1 next cycle; counter <= 0.
REQ-030 On frame_start_in with frame_active_out=0: no publish; counter <= 0; frame_active_out <= 1.
REQ-031 pixel_valid_in coincident with frame_start_in is a protocol violation; that pixel SHALL be dropped (valid_d <= 0).
REQ-032 Counted bits SHALL be ignored when frame_active_out=0.
REQ-033 Outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-034 On rst_in, the block SHALL set: FSM=IDLE; cfg_ready_out=1; commit_pending_out=0; all active bounds and shadows = DEF_LOWER/DEF_UPPER; counter=0; valid_d=0; mask_count_out=0; mask_count_valid_out=0; frame_active_out=0.
REQ-035 Reset SHALL take priority over all inputs, including mid-PENDING (commit discarded) and mid-frame (count discarded).

Verification
REQ-036 Bench SHALL cover: write addr0=20, addr1=200, commit, frame_start -> lower_bound_out=20, upper_bound_out=200 the cycle after frame_start; unchanged before it.
REQ-037 Bench SHALL cover: commit then write attempt while PENDING -> cfg_ready_out=0, shadow unchanged, applied bounds equal pre-commit shadows.
REQ-038 Bench SHALL cover: frame_start, then 10 pixels with 7 masks=1 (last mask arriving on the next frame_start cycle) -> mask_count_out=7 with a one-cycle valid pulse.
REQ-039 Bench SHALL cover: COUNT_W=4, 20 masks=1 in a frame -> mask_count_out=15.
REQ-040 Bench SHALL cover: commit coincident with frame_start -> bounds unchanged after it; applied only at the following frame_start.
REQ-041 Bench SHALL cover: rst_in asserted while PENDING mid-frame -> all outputs at reset values next cycle; the next frame_start produces no mask_count_valid_out pulse.
